// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared convertor package: sizing helpers and parameter-legality checks
// for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

  // Occupancy counts RAM entries plus the output stage, so one extra bit.
  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit depth_ok(input int unsigned depth, input int unsigned addr_width);
    return (clog2(depth) == addr_width) && ((64'd1 << addr_width) == 64'(depth));
  endfunction

  function automatic bit thresh_ok(input int unsigned thresh, input int unsigned depth);
    return (thresh >= 1) && (thresh <= depth + 1);
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready write and read handshake bundle for ram_fifo_ctrl.
interface ram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/ram_fifo_ctrl_fifo_ptr_cnt.sv
// Write/read pointers, RAM occupancy and registered write-accept for
// the RAM-backed FIFO controller.
module fifo_ptr_cnt #(
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  wr_inc_i,
  input  logic                  rd_inc_i,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic [ADDR_WIDTH:0]   ram_cnt_o,
  output logic                  s_ready_o
);
  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_next;
  logic                  s_ready_q, s_ready_d;

  always_comb begin
    cnt_next  = cnt_q + CW'(wr_inc_i) - CW'(rd_inc_i);
    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(wr_inc_i);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(rd_inc_i);
    cnt_d     = cnt_next;
    // A same-cycle pop does not reopen a full RAM; accept follows one edge later.
    s_ready_d = (cnt_next != CW'(MEM_DEPTH)) & ~flush_i;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign ram_cnt_o = cnt_q;
  assign s_ready_o = s_ready_q;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external combinational-read RAM with a registered
// first-word-fall-through output stage. Optional RAM_FIFO_CTRL_BYPASS_EN.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AF_THRESH  = 1020
) (
  input  logic                                 ACLK,
  input  logic                                 sysReset,
  input  logic                                 flush,
  ram_fifo_ctrl_if.slave                       bus,
  output logic [level_width(ADDR_WIDTH)-1:0]   level,
  output logic                                 almost_full,
  output logic                                 mem_wr_en,
  output logic [ADDR_WIDTH-1:0]                mem_wr_addr,
  output logic [ADDR_WIDTH-1:0]                mem_rd_addr,
  output logic [DATA_WIDTH-1:0]                mem_data_in,
  input  logic [DATA_WIDTH-1:0]                mem_data_out
);
  localparam int unsigned LW = level_width(ADDR_WIDTH);

  if (!depth_ok(MEM_DEPTH, ADDR_WIDTH)) begin : g_bad_depth
    $error("ram_fifo_ctrl: MEM_DEPTH must equal 2**ADDR_WIDTH");
  end
  if (!thresh_ok(AF_THRESH, MEM_DEPTH)) begin : g_bad_thresh
    $error("ram_fifo_ctrl: AF_THRESH must lie in 1..MEM_DEPTH+1");
  end

  logic                  push, load, byp, wr_inc, stage_free;
  logic                  s_ready_q;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  fifo_ptr_cnt #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr_cnt (
    .clk_i     (ACLK),
    .rst_ni    (sysReset),
    .flush_i   (flush),
    .wr_inc_i  (wr_inc),
    .rd_inc_i  (load & ~flush),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .ram_cnt_o (ram_cnt),
    .s_ready_o (s_ready_q)
  );

  always_comb begin
    stage_free = ~m_valid_q | bus.m_ready;
    push       = bus.s_valid & s_ready_q;
    load       = (ram_cnt != '0) & stage_free;
`ifdef RAM_FIFO_CTRL_BYPASS_EN
    byp        = push & (ram_cnt == '0) & stage_free;
`else
    byp        = 1'b0;
`endif
    wr_inc     = push & ~byp;

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    // load and byp are exclusive: load needs a non-empty RAM, byp an empty one.
    if (flush) begin
      m_valid_d = 1'b0;
    end else if (load) begin
      m_data_d  = mem_data_out;
      m_valid_d = 1'b1;
    end else if (byp) begin
      m_data_d  = bus.s_data;
      m_valid_d = 1'b1;
    end else if (m_valid_q & bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge sysReset) begin
    if (!sysReset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign level        = ram_cnt + LW'(m_valid_q);
  assign almost_full  = (32'(level) >= AF_THRESH);
  assign mem_wr_en    = wr_inc;
  assign mem_wr_addr  = wr_ptr;
  assign mem_rd_addr  = rd_ptr;
  assign mem_data_in  = bus.s_data;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: directed test-plan checks plus
// randomized traffic against a queue-based reference model.
module tb_ram_fifo_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned AFT   = 4;
`ifdef RAM_FIFO_CTRL_BYPASS_EN
  localparam int unsigned LAT = 0;
`else
  localparam int unsigned LAT = 1;
`endif

  logic          ACLK = 1'b0;
  logic          sysReset;
  logic          flush;
  logic [AW:0]   level;
  logic          almost_full;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus_if ();

  ram_fifo_ctrl #(
    .MEM_DEPTH  (DEPTH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .AF_THRESH  (AFT)
  ) dut (
    .ACLK         (ACLK),
    .sysReset     (sysReset),
    .flush        (flush),
    .bus          (bus_if),
    .level        (level),
    .almost_full  (almost_full),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_rd_addr  (mem_rd_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 ACLK = ~ACLK;

  // External RAM: single write port, combinational read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge ACLK) if (mem_wr_en) ram[mem_wr_addr] <= mem_data_in;
  assign mem_data_out = ram[mem_rd_addr];

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of held entries, each tagged with its push edge.
  // The head is visible once LAT edges have passed since it was pushed.
  typedef struct {
    logic [DW-1:0] d;
    int unsigned   e;
  } ent_t;
  ent_t        q[$];
  int unsigned edge_n;
  bit          m_sready;

  function automatic bit mvis();
    return (q.size() > 0) && ((edge_n - q[0].e) >= LAT);
  endfunction

  always @(posedge ACLK or negedge sysReset) begin : model
    bit v, pushok;
    int unsigned ramn;
    if (!sysReset) begin
      q.delete();
      m_sready = 1'b0;
      edge_n   = 0;
    end else begin
      v      = mvis();
      pushok = bus_if.s_valid && m_sready;
      edge_n = edge_n + 1;
      if (flush) begin
        q.delete();
        m_sready = 1'b0;
      end else begin
        if (v && bus_if.m_ready) void'(q.pop_front());
        if (pushok) q.push_back('{d: bus_if.s_data, e: edge_n});
        ramn     = q.size() - 32'(mvis());
        m_sready = (ramn != DEPTH);
      end
    end
  end

  always @(negedge ACLK) begin : compare
    bit v, psh, byp;
    int unsigned ramn;
    if (sysReset) begin
      v    = mvis();
      ramn = q.size() - 32'(v);
      psh  = bus_if.s_valid && m_sready;
      byp  = (LAT == 0) && psh && (ramn == 0) && (!v || bus_if.m_ready);
      chk("s_ready", 32'(bus_if.s_ready), 32'(m_sready));
      chk("m_valid", 32'(bus_if.m_valid), 32'(v));
      if (v) chk("m_data", 32'(bus_if.m_data), 32'(q[0].d));
      chk("level", 32'(level), q.size());
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AFT));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(psh && !byp));
      if (psh && !byp) chk("mem_data_in", 32'(mem_data_in), 32'(bus_if.s_data));
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    bus_if.s_valid = v;
    bus_if.s_data  = d;
    bus_if.m_ready = r;
    flush          = f;
    @(posedge ACLK);
    #2;
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_s_ready"}, 32'(bus_if.s_ready), 0);
    chk({tag, "_m_valid"}, 32'(bus_if.m_valid), 0);
    chk({tag, "_m_data"},  32'(bus_if.m_data), 0);
    chk({tag, "_level"},   32'(level), 0);
    chk({tag, "_af"},      32'(almost_full), 0);
  endtask

  initial begin : stim
    logic [DW-1:0] outs[$];
    int first, last;
    logic v, r, f;

    sysReset = 1'b0;
    flush = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.m_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    #2;
    reset_outputs_chk("reset");
    chk("model_empty", q.size(), 0);
    sysReset = 1'b1;
    cyc(0, 8'h00, 0, 0);
    chk("ready_after_reset", 32'(bus_if.s_ready), 1);

    // Single push, latency.
    cyc(1, 8'hA1, 0, 0);
`ifdef RAM_FIFO_CTRL_BYPASS_EN
    chk("a1_valid_at_edge", 32'(bus_if.m_valid), 1);
    chk("a1_data_at_edge", 32'(bus_if.m_data), 32'h A1);
`else
    chk("a1_valid_at_edge", 32'(bus_if.m_valid), 0);
`endif
    chk("a1_level", 32'(level), 1);
    cyc(0, 8'h00, 0, 0);
    chk("a1_valid_next", 32'(bus_if.m_valid), 1);
    chk("a1_data_next", 32'(bus_if.m_data), 32'hA1);

    // Fill to capacity.
    cyc(0, 8'h00, 0, 1);
    chk("ready_low_after_flush", 32'(bus_if.s_ready), 0);
    cyc(0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'(8'h10 + i), 0, 0);
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 4));
    end
    chk("full_ready", 32'(bus_if.s_ready), 0);
    chk("full_head", 32'(bus_if.m_data), 32'h10);
    chk("model_level_full", q.size(), 5);

    // Pop while full: the offered write is refused, accept returns next edge.
    cyc(1, 8'h99, 1, 0);
    chk("pop_data", 32'(bus_if.m_data), 32'h11);
    chk("pop_level", 32'(level), 4);
    chk("pop_ready_next", 32'(bus_if.s_ready), 1);
    cyc(0, 8'h00, 0, 0);
    chk("pop_level_hold", 32'(level), 4);

    // Continuous stream with pointer wrap.
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);
    first = -1;
    last  = -1;
    for (int i = 0; i < 19; i++) begin
      if (i < 16) cyc(1, 8'(i), 1, 0);
      else        cyc(0, 8'h00, 1, 0);
      if (bus_if.m_valid) begin
        outs.push_back(bus_if.m_data);
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_count", outs.size(), 16);
    foreach (outs[k]) chk("stream_order", 32'(outs[k]), 32'(k));
    chk("stream_bubbles", 32'(last - first), 15);

    // Flush with a concurrent write.
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    chk("pre_flush_level", 32'(level), 3);
    cyc(1, 8'h77, 0, 1);
    chk("flush_level", 32'(level), 0);
    chk("flush_valid", 32'(bus_if.m_valid), 0);
    chk("flush_ready", 32'(bus_if.s_ready), 0);
    cyc(0, 8'h00, 0, 0);
    chk("flush_discard_level", 32'(level), 0);
    chk("flush_ready_back", 32'(bus_if.s_ready), 1);

    // Asynchronous reset mid-stream.
    cyc(1, 8'h55, 0, 0);
    cyc(1, 8'h66, 0, 0);
    chk("mid_level", 32'(level), 2);
    sysReset = 1'b0;
    #1;
    reset_outputs_chk("async_rst");
    @(posedge ACLK);
    #2;
    sysReset = 1'b1;
    cyc(0, 8'h00, 0, 0);

    // Randomized traffic: a backpressure-heavy phase, then a drain-heavy phase.
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      r = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 63) == 0);
      if (n == 2000) begin
        sysReset = 1'b0;
        #1;
        chk("rand_rst_level", 32'(level), 0);
        sysReset = 1'b1;
      end
      cyc(v, 8'($urandom), r, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
